// File: rtl/oflow_conflict_resolve_multi.sv
// Multi-pass ID conflict resolver over the PE score boards. Optional stats via OFLOW_CR_STATS_EN.
// Latency: passes*(2*num_objects+2) cycles from accepted start_cr to the done_cr pulse.
// Backpressure: none; the score board must answer a read on the cycle after the select.
module oflow_conflict_resolve_multi #(
  parameter int NUM_PE      = 8,
  parameter int ROWS_PER_PE = 4,
  parameter int ID_LEN      = 6,
  parameter int SCORE_LEN   = 16,
  parameter int MAX_ITER_TH = 4,
  localparam int MAX_OBJ    = NUM_PE * ROWS_PER_PE,
  localparam int OBJ_W      = $clog2(MAX_OBJ + 1),
  localparam int ROW_W      = $clog2(ROWS_PER_PE),
  localparam int PE_W       = $clog2(NUM_PE)
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start_cr,
  input  logic [OBJ_W-1:0]     num_objects,
  output logic                 done_cr,
  output logic                 cr_unresolved,
  input  logic [SCORE_LEN-1:0] score_to_cr,
  input  logic [ID_LEN-1:0]    id_to_cr,
  output logic [ROW_W-1:0]     row_sel_from_cr,
  output logic [PE_W-1:0]      pe_sel_from_cr,
  output logic [ROW_W-1:0]     row_to_change,
  output logic [PE_W-1:0]      pe_to_change,
  output logic                 data_to_score_board,
  output logic                 write_to_pointer
`ifdef OFLOW_CR_STATS_EN
  ,
  output logic [15:0]          cr_conflict_count
`endif
);

  localparam int TBL_DEPTH = 1 << ID_LEN;
  localparam int PASS_W    = $clog2(MAX_ITER_TH + 1);
  localparam logic [ID_LEN-1:0] NULL_ID   = '1;
  localparam logic [OBJ_W-1:0]  MAX_OBJ_L = OBJ_W'(MAX_OBJ);
  localparam logic [PASS_W-1:0] MAX_PASS  = PASS_W'(MAX_ITER_TH);
  localparam logic [PE_W-1:0]   LAST_PE   = PE_W'(NUM_PE - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, READ, CHECK, PASS_END, DONE
  } state_t;

  state_t              state;
  logic [PASS_W-1:0]   pass_q;
  logic [OBJ_W-1:0]    k_q;
  logic [OBJ_W-1:0]    n_q;
  logic                conflict_q;

  // Ownership table: valid bits are reset/cleared per pass, payload is don't-care when invalid.
  logic [TBL_DEPTH-1:0] tbl_vld;
  logic [SCORE_LEN-1:0] tbl_score [TBL_DEPTH];
  logic [PE_W-1:0]      tbl_pe    [TBL_DEPTH];
  logic [ROW_W-1:0]     tbl_row   [TBL_DEPTH];

  logic [OBJ_W-1:0] n_clamped;
  logic [OBJ_W-1:0] k_next;
  logic             id_hit;
  logic             id_owned;
  logic             new_wins;
  logic             tbl_wr;

  assign n_clamped = (num_objects > MAX_OBJ_L) ? MAX_OBJ_L : num_objects;
  assign k_next    = k_q + 1'b1;
  assign id_hit    = (id_to_cr != NULL_ID);
  assign id_owned  = tbl_vld[id_to_cr];
  // Strict less-than: on equal scores the earlier object index keeps the ID.
  assign new_wins  = (score_to_cr < tbl_score[id_to_cr]);
  assign tbl_wr    = id_hit && (!id_owned || new_wins);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state               <= IDLE;
      pass_q              <= '0;
      k_q                 <= '0;
      n_q                 <= '0;
      conflict_q          <= 1'b0;
      tbl_vld             <= '0;
      done_cr             <= 1'b0;
      cr_unresolved       <= 1'b0;
      row_sel_from_cr     <= '0;
      pe_sel_from_cr      <= '0;
      row_to_change       <= '0;
      pe_to_change        <= '0;
      data_to_score_board <= 1'b0;
      write_to_pointer    <= 1'b0;
`ifdef OFLOW_CR_STATS_EN
      cr_conflict_count   <= '0;
`endif
    end else begin
      done_cr             <= 1'b0;
      write_to_pointer    <= 1'b0;
      data_to_score_board <= 1'b0;
      row_to_change       <= '0;
      pe_to_change        <= '0;

      case (state)
        IDLE: begin
          if (start_cr) begin
            state         <= CLEAR;
            pass_q        <= PASS_W'(1);
            n_q           <= n_clamped;
            cr_unresolved <= 1'b0;
`ifdef OFLOW_CR_STATS_EN
            cr_conflict_count <= '0;
`endif
          end
        end

        CLEAR: begin
          tbl_vld         <= '0;
          conflict_q      <= 1'b0;
          k_q             <= '0;
          row_sel_from_cr <= '0;
          pe_sel_from_cr  <= '0;
          if (n_q == '0) begin
            state         <= DONE;
            done_cr       <= 1'b1;
            cr_unresolved <= 1'b0;
          end else begin
            state <= READ;
          end
        end

        READ: state <= CHECK;

        CHECK: begin
          if (id_hit && !id_owned) begin
            tbl_vld[id_to_cr] <= 1'b1;
          end
          if (id_hit && id_owned) begin
            conflict_q          <= 1'b1;
            write_to_pointer    <= 1'b1;
            data_to_score_board <= 1'b1;
            if (new_wins) begin
              pe_to_change  <= tbl_pe[id_to_cr];
              row_to_change <= tbl_row[id_to_cr];
            end else begin
              pe_to_change  <= pe_sel_from_cr;
              row_to_change <= row_sel_from_cr;
            end
`ifdef OFLOW_CR_STATS_EN
            if (cr_conflict_count != 16'hFFFF) begin
              cr_conflict_count <= cr_conflict_count + 16'd1;
            end
`endif
          end

          // PE-fastest walk; a wrap past the last row is harmless since CLEAR rewinds.
          k_q <= k_next;
          if (pe_sel_from_cr == LAST_PE) begin
            pe_sel_from_cr  <= '0;
            row_sel_from_cr <= row_sel_from_cr + 1'b1;
          end else begin
            pe_sel_from_cr <= pe_sel_from_cr + 1'b1;
          end
          state <= (k_next == n_q) ? PASS_END : READ;
        end

        PASS_END: begin
          if (conflict_q && (pass_q < MAX_PASS)) begin
            pass_q <= pass_q + 1'b1;
            state  <= CLEAR;
          end else begin
            state         <= DONE;
            done_cr       <= 1'b1;
            cr_unresolved <= conflict_q;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CHECK && tbl_wr) begin
      tbl_score[id_to_cr] <= score_to_cr;
      tbl_pe[id_to_cr]    <= pe_sel_from_cr;
      tbl_row[id_to_cr]   <= row_sel_from_cr;
    end
  end

endmodule

// File: tb/tb_oflow_conflict_resolve_multi.sv
// Scoreboard bench for oflow_conflict_resolve_multi with a behavioural score-board model.
module tb_oflow_conflict_resolve_multi;

  localparam int NUM_PE      = 8;
  localparam int ROWS_PER_PE = 4;
  localparam int ID_LEN      = 6;
  localparam int SCORE_LEN   = 16;
  localparam int MAX_ITER_TH = 4;
  localparam int NOBJ        = NUM_PE * ROWS_PER_PE;
  localparam int OBJ_W       = $clog2(NOBJ + 1);
  localparam int ROW_W       = $clog2(ROWS_PER_PE);
  localparam int PE_W        = $clog2(NUM_PE);
  localparam int NSLOT       = 4;

  logic                 clk = 1'b0;
  logic                 reset_N = 1'b1;
  logic                 start_cr = 1'b0;
  logic [OBJ_W-1:0]     num_objects = '0;
  logic                 done_cr;
  logic                 cr_unresolved;
  logic [SCORE_LEN-1:0] score_to_cr = '0;
  logic [ID_LEN-1:0]    id_to_cr = '1;
  logic [ROW_W-1:0]     row_sel_from_cr;
  logic [PE_W-1:0]      pe_sel_from_cr;
  logic [ROW_W-1:0]     row_to_change;
  logic [PE_W-1:0]      pe_to_change;
  logic                 data_to_score_board;
  logic                 write_to_pointer;
`ifdef OFLOW_CR_STATS_EN
  logic [15:0]          cr_conflict_count;
`endif

  oflow_conflict_resolve_multi #(
    .NUM_PE(NUM_PE), .ROWS_PER_PE(ROWS_PER_PE), .ID_LEN(ID_LEN),
    .SCORE_LEN(SCORE_LEN), .MAX_ITER_TH(MAX_ITER_TH)
  ) dut (
    .clk(clk), .reset_N(reset_N), .start_cr(start_cr), .num_objects(num_objects),
    .done_cr(done_cr), .cr_unresolved(cr_unresolved),
    .score_to_cr(score_to_cr), .id_to_cr(id_to_cr),
    .row_sel_from_cr(row_sel_from_cr), .pe_sel_from_cr(pe_sel_from_cr),
    .row_to_change(row_to_change), .pe_to_change(pe_to_change),
    .data_to_score_board(data_to_score_board), .write_to_pointer(write_to_pointer)
`ifdef OFLOW_CR_STATS_EN
    , .cr_conflict_count(cr_conflict_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Score-board model: registered read, pointer advance on strobe, saturating at the last slot.
  logic [ID_LEN-1:0]    cand_id [NOBJ][NSLOT];
  logic [SCORE_LEN-1:0] cand_sc [NOBJ][NSLOT];
  int                   ptr [NOBJ];

  always @(posedge clk) begin
    int o;
    int w;
    o = int'(row_sel_from_cr) * NUM_PE + int'(pe_sel_from_cr);
    score_to_cr <= cand_sc[o][ptr[o]];
    id_to_cr    <= cand_id[o][ptr[o]];
    if (write_to_pointer && data_to_score_board) begin
      w = int'(row_to_change) * NUM_PE + int'(pe_to_change);
      if (ptr[w] < NSLOT - 1) ptr[w] = ptr[w] + 1;
    end
  end

  typedef struct packed {
    logic [PE_W-1:0]  pe;
    logic [ROW_W-1:0] row;
  } wr_t;

  typedef struct {
    bit unres;
    int lat_lo;
    int lat_hi;
    int nwr;
  } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    tests = 0;
  int    fails = 0;
  int    start_edge = 0;
  int    done_cnt = 0;
  int    frame_wr = 0;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or a completion.
  always @(negedge clk) begin
    wr_t   e;
    done_t d;
    int    lat;
    if (reset_N) begin
      if (write_to_pointer) begin
        frame_wr++;
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_wr.pop_front();
          chk("write_pe", pe_to_change, e.pe);
          chk("write_row", row_to_change, e.row);
          chk("write_data", data_to_score_board, 1);
        end
      end
      if (done_cr) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          d = exp_done.pop_front();
          lat = cyc - start_edge;
          tests++;
          if (lat < d.lat_lo || lat > d.lat_hi) begin
            fails++;
            $display("FAIL done_latency: actual=%0d required=%0d..%0d", lat, d.lat_lo, d.lat_hi);
          end
          chk("done_unresolved", cr_unresolved, d.unres);
          chk("writes_pending_at_done", exp_wr.size(), 0);
          chk("writes_in_frame", frame_wr, d.nwr);
`ifdef OFLOW_CR_STATS_EN
          chk("conflict_count", cr_conflict_count, d.nwr);
`endif
        end
      end
    end
  end

  task automatic clear_model();
    for (int o = 0; o < NOBJ; o++) begin
      ptr[o] = 0;
      for (int s = 0; s < NSLOT; s++) begin
        cand_id[o][s] = '1;
        cand_sc[o][s] = '0;
      end
    end
  endtask

  task automatic set_slot(input int o, input int s, input int id, input int sc);
    cand_id[o][s] = ID_LEN'(id);
    cand_sc[o][s] = SCORE_LEN'(sc);
  endtask

  task automatic push_wr(input int pe, input int row);
    wr_t e;
    e.pe  = PE_W'(pe);
    e.row = ROW_W'(row);
    exp_wr.push_back(e);
  endtask

  task automatic issue_start(input int n);
    @(negedge clk);
    num_objects = OBJ_W'(n);
    start_cr    = 1'b1;
    start_edge  = cyc + 1;
    frame_wr    = 0;
    @(negedge clk);
    start_cr = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit unres, input int lo, input int hi,
                           input int nwr, input bit busy_pulse);
    done_t d;
    int    target;
    int    t;
    d.unres = unres; d.lat_lo = lo; d.lat_hi = hi; d.nwr = nwr;
    exp_done.push_back(d);
    target = done_cnt + 1;
    issue_start(n);
    if (n > 0) chk("unresolved_cleared_on_start", cr_unresolved, 0);
    if (busy_pulse) begin
      @(negedge clk);
      start_cr = 1'b1;
      @(negedge clk);
      start_cr = 1'b0;
    end
    t = 0;
    while (done_cnt < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < target) begin
      chk("done_timeout", 0, 1);
      exp_done.delete();
      exp_wr.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_done_cr"}, done_cr, 0);
    chk({tag, "_cr_unresolved"}, cr_unresolved, 0);
    chk({tag, "_write_to_pointer"}, write_to_pointer, 0);
    chk({tag, "_data_to_score_board"}, data_to_score_board, 0);
    chk({tag, "_row_sel"}, row_sel_from_cr, 0);
    chk({tag, "_pe_sel"}, pe_sel_from_cr, 0);
    chk({tag, "_row_to_change"}, row_to_change, 0);
    chk({tag, "_pe_to_change"}, pe_to_change, 0);
`ifdef OFLOW_CR_STATS_EN
    chk({tag, "_conflict_count"}, cr_conflict_count, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_model();
    #3 reset_N = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_N = 1'b1;
    repeat (2) @(negedge clk);

    // No conflicts: ids 5,6,7.
    clear_model();
    set_slot(0, 0, 5, 10); set_slot(1, 0, 6, 10); set_slot(2, 0, 7, 10);
    run_frame(3, 0, 8, 8, 0, 0);

    // Simple conflict: stored owner obj0 (score 100) loses to obj1 (score 40).
    clear_model();
    set_slot(0, 0, 9, 100); set_slot(0, 1, 12, 70); set_slot(1, 0, 9, 40);
    push_wr(0, 0);
    run_frame(2, 0, 12, 12, 1, 0);

    // Tie: the later object loses.
    clear_model();
    set_slot(0, 0, 3, 50); set_slot(1, 0, 3, 50);
    push_wr(1, 0);
    run_frame(2, 0, 12, 12, 1, 0);

    // Unresolved: both objects always claim id 2.
    clear_model();
    for (int s = 0; s < NSLOT; s++) begin
      set_slot(0, s, 2, 10);
      set_slot(1, s, 2, 20);
    end
    for (int p = 0; p < MAX_ITER_TH; p++) push_wr(1, 0);
    run_frame(2, 1, 24, 24, MAX_ITER_TH, 0);
    repeat (3) @(negedge clk);
    chk("unresolved_holds", cr_unresolved, 1);

    // All NULL ids with a start pulse while busy.
    clear_model();
    run_frame(4, 0, 10, 10, 0, 1);

    // Zero objects.
    run_frame(0, 0, 1, 2, 0, 0);

    // Conflict across rows: obj9 (pe1,row1) loses id 20 to obj17 (pe1,row2).
    clear_model();
    for (int o = 0; o < 18; o++) set_slot(o, 0, o, 100);
    set_slot(9, 0, 20, 5); set_slot(9, 1, 40, 5);
    set_slot(17, 0, 20, 3);
    push_wr(1, 1);
    run_frame(18, 0, 76, 76, 1, 0);

    // num_objects above capacity is clamped to 32.
    clear_model();
    for (int o = 0; o < NOBJ; o++) set_slot(o, 0, o, 1);
    run_frame(40, 0, 66, 66, 0, 0);

    // Reset during CHECK of pass 2, then a normal frame.
    clear_model();
    set_slot(0, 0, 9, 100); set_slot(0, 1, 12, 70); set_slot(1, 0, 9, 40);
    push_wr(0, 0);
    issue_start(2);
    while (cyc < start_edge + 8) @(negedge clk);
    reset_N = 1'b0;
    #1;
    check_all_zero("midreset");
    chk("midreset_pass1_write_seen", exp_wr.size(), 0);
    @(negedge clk);
    reset_N = 1'b1;
    exp_wr.delete();
    @(negedge clk);
    clear_model();
    set_slot(0, 0, 5, 10); set_slot(1, 0, 6, 10); set_slot(2, 0, 7, 10);
    run_frame(3, 0, 8, 8, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
